// File: rtl/ex_mem_reg_if.sv
// EX->MEM pipeline register bus.
// Master drives the EX side and the MEM controls; slave is the register.
interface ex_mem_reg_if;
  logic        EX_Valid;
  logic [31:0] EX_ALU1Out;
  logic        EX_Overflow;
  logic        EX_OvfCheck;
  logic        EX_RegWrite;
  logic        EX_MemR;
  logic        EX_MemW;
  logic [4:0]  EX_Rd;
  logic [31:0] EX_RtData;
  logic [31:0] EX_PC;
  logic        EX_ExcIn;
  logic [4:0]  EX_ExcCodeIn;
  logic        MEM_Stall;
  logic        MEM_Flush;
  logic        EX_Ready;
  logic        MEM_Valid;
  logic [31:0] MEM_ALU1Out;
  logic        MEM_RegWrite;
  logic        MEM_MemR;
  logic        MEM_MemW;
  logic [4:0]  MEM_Rd;
  logic [31:0] MEM_RtData;
  logic [31:0] MEM_PC;
  logic        MEM_Exc;
  logic [4:0]  MEM_ExcCode;
  logic        Drain;

  modport master (
    output EX_Valid, EX_ALU1Out, EX_Overflow,
    output EX_OvfCheck, EX_RegWrite, EX_MemR,
    output EX_MemW, EX_Rd, EX_RtData, EX_PC,
    output EX_ExcIn, EX_ExcCodeIn,
    output MEM_Stall, MEM_Flush,
    input  EX_Ready, MEM_Valid, MEM_ALU1Out,
    input  MEM_RegWrite, MEM_MemR, MEM_MemW,
    input  MEM_Rd, MEM_RtData, MEM_PC,
    input  MEM_Exc, MEM_ExcCode, Drain
  );

  modport slave (
    input  EX_Valid, EX_ALU1Out, EX_Overflow,
    input  EX_OvfCheck, EX_RegWrite, EX_MemR,
    input  EX_MemW, EX_Rd, EX_RtData, EX_PC,
    input  EX_ExcIn, EX_ExcCodeIn,
    input  MEM_Stall, MEM_Flush,
    output EX_Ready, MEM_Valid, MEM_ALU1Out,
    output MEM_RegWrite, MEM_MemR, MEM_MemW,
    output MEM_Rd, MEM_RtData, MEM_PC,
    output MEM_Exc, MEM_ExcCode, Drain
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with exception capture and drain FSM.
// Define OVF_TRAP_EN to trap on signed overflow of add/addi/sub.
module ex_mem_reg (
  input logic         clk,
  input logic         rstn,
  ex_mem_reg_if.slave bus
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t     state;
  logic       ovf;
  logic       live;
  logic       exc;
  logic [4:0] code;

`ifdef OVF_TRAP_EN
  assign ovf = bus.EX_Valid & bus.EX_OvfCheck
             & bus.EX_Overflow;
`else
  assign ovf = 1'b0;
`endif

  // slot is real only while not draining after a trap
  assign live = bus.EX_Valid & (state == RUN);

  // upstream exception outranks overflow trap
  always_comb begin
    exc  = 1'b0;
    code = 5'h00;
    unique case (1'b1)
      bus.EX_ExcIn: begin
        exc  = 1'b1;
        code = bus.EX_ExcCodeIn;
      end
      ovf: begin
        exc  = 1'b1;
        code = 5'h0C;
      end
      default: ;
    endcase
  end

  assign bus.EX_Ready = ~bus.MEM_Stall | bus.MEM_Flush;
  assign bus.Drain    = (state == DRAIN);

  // reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= RUN;
      bus.MEM_Valid    <= 1'b0;
      bus.MEM_ALU1Out  <= 32'h0;
      bus.MEM_RegWrite <= 1'b0;
      bus.MEM_MemR     <= 1'b0;
      bus.MEM_MemW     <= 1'b0;
      bus.MEM_Rd       <= 5'h0;
      bus.MEM_RtData   <= 32'h0;
      bus.MEM_PC       <= 32'h0;
      bus.MEM_Exc      <= 1'b0;
      bus.MEM_ExcCode  <= 5'h0;
    end else if (bus.MEM_Flush) begin
      state            <= RUN;
      bus.MEM_Valid    <= 1'b0;
      bus.MEM_RegWrite <= 1'b0;
      bus.MEM_MemR     <= 1'b0;
      bus.MEM_MemW     <= 1'b0;
      bus.MEM_Exc      <= 1'b0;
      bus.MEM_ExcCode  <= 5'h0;
    end else if (!bus.MEM_Stall) begin
      bus.MEM_ALU1Out  <= bus.EX_ALU1Out;
      bus.MEM_Rd       <= bus.EX_Rd;
      bus.MEM_RtData   <= bus.EX_RtData;
      bus.MEM_PC       <= bus.EX_PC;
      bus.MEM_Valid    <= live;
      bus.MEM_Exc      <= live & exc;
      bus.MEM_ExcCode  <= live ? code : 5'h0;
      bus.MEM_RegWrite <= live & ~exc
                        & bus.EX_RegWrite;
      bus.MEM_MemR     <= live & ~exc
                        & bus.EX_MemR;
      bus.MEM_MemW     <= live & ~exc
                        & bus.EX_MemW;
      if (live & exc)
        state <= DRAIN;
    end
  end

endmodule
